icache_nway: RTL and testbench



---
 rtl/icache_nway.sv | 199 +++++++++++++++++++
 tb/tb_icache_nway.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache: two-word hit path, line refill over a
// word-per-beat burst port, invalid-first/round-robin replacement, whole-cache flush.
module icache_nway #(
  parameter int WAYS       = 2,
  parameter int SETS       = 128,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_i,
  input  logic [31:0] cpu_addr_i,
  input  logic        flush_i,
  output logic        hit_o,
  output logic        inst_valid_o,
  output logic [31:0] inst1_o,
  output logic        inst2_valid_o,
  output logic [31:0] inst2_o,
  output logic        stall_o,
  output logic        mem_ren_o,
  output logic [31:0] mem_araddr_o,
  input  logic        mem_arready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);
  localparam int WO  = $clog2(LINE_WORDS);
  localparam int OFF = WO + 2;
  localparam int IDX = $clog2(SETS);
  localparam int TAG = 32 - OFF - IDX;
  localparam int VPW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LW  = LINE_WORDS * 32;

  // state  | meaning
  // IDLE   | waiting for a request; executes flushes
  // LOOKUP | tag compare on RAM output, hit returns data
  // MISS   | line read request held until accepted
  // REFILL | collecting beats into the refill buffer
  // WRITE  | fill victim way and return data from buffer
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS, S_REFILL, S_WRITE} state_t;
  state_t state_q, state_d;

  logic [31:0]     req_addr_q, req_addr_d;
  logic            flush_pend_q, flush_pend_d;
  logic [WO-1:0]   cnt_q, cnt_d;
  logic [WAYS-1:0] valid_q [SETS];
  logic [VPW-1:0]  vptr_q [SETS];
  logic [LW-1:0]   rbuf_q;

  logic [LW-1:0]   data_ram [WAYS][SETS];
  logic [TAG-1:0]  tag_ram  [WAYS][SETS];
  logic [LW-1:0]   data_rd  [WAYS];
  logic [TAG-1:0]  tag_rd   [WAYS];

  logic [IDX-1:0]  req_idx, rd_idx;
  logic [TAG-1:0]  req_tag;
  logic [WAYS-1:0] set_valid, victim_oh;
  logic            lookup_hit, found, accept, flush_now, ram_we, beat_we, line_valid;
  logic [LW-1:0]   line_hit, line_sel;
  logic [WO-1:0]   wo, wo_n;
  logic            unused_lsb;

  assign req_idx    = req_addr_q[OFF +: IDX];
  assign req_tag    = req_addr_q[31 -: TAG];
  assign rd_idx     = accept ? cpu_addr_i[OFF +: IDX] : req_idx;
  assign set_valid  = valid_q[req_idx];
  assign unused_lsb = ^req_addr_q[1:0];

  always_comb begin
    lookup_hit = 1'b0;
    line_hit   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (set_valid[w] && tag_rd[w] == req_tag) begin
        lookup_hit = 1'b1;
        line_hit   = line_hit | data_rd[w];
      end
    end
  end

  always_comb begin
    victim_oh = '0;
    found     = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !set_valid[w]) begin
        victim_oh[w] = 1'b1;
        found        = 1'b1;
      end
    end
    if (!found) victim_oh[vptr_q[req_idx]] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    flush_pend_d = flush_pend_q | flush_i;
    cnt_d        = cnt_q;
    accept       = 1'b0;
    flush_now    = 1'b0;
    ram_we       = 1'b0;
    beat_we      = 1'b0;
    line_valid   = 1'b0;
    hit_o        = 1'b0;
    stall_o      = 1'b0;
    mem_ren_o    = 1'b0;
    mem_araddr_o = '0;
    case (state_q)
      S_IDLE: begin
        stall_o = (cpu_req_i | flush_pend_q) & ~rst;
        if (flush_i || flush_pend_q) begin
          flush_now    = 1'b1;
          flush_pend_d = 1'b0;
        end else if (cpu_req_i) begin
          accept = 1'b1;
        end
      end
      S_LOOKUP: begin
        stall_o = ~lookup_hit;
        if (lookup_hit) begin
          hit_o      = 1'b1;
          line_valid = 1'b1;
          if (cpu_req_i) accept = 1'b1;
          else state_d = S_IDLE;
        end else begin
          state_d = S_MISS;
        end
      end
      S_MISS: begin
        stall_o      = 1'b1;
        mem_ren_o    = 1'b1;
        mem_araddr_o = {req_addr_q[31:OFF], {OFF{1'b0}}};
        if (mem_arready_i) begin
          cnt_d   = '0;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        stall_o = 1'b1;
        if (mem_rvalid_i) begin
          beat_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (&cnt_q) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        ram_we     = 1'b1;
        line_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      state_d    = S_LOOKUP;
      req_addr_d = cpu_addr_i;
    end
  end

  assign wo            = req_addr_q[OFF-1:2];
  assign wo_n          = wo + 1'b1;
  assign line_sel      = (state_q == S_WRITE) ? rbuf_q : line_hit;
  assign inst_valid_o  = line_valid;
  assign inst2_valid_o = line_valid & ~(&wo);
  assign inst1_o       = line_valid ? line_sel[{wo, 5'b0} +: 32] : 32'h0;
  assign inst2_o       = inst2_valid_o ? line_sel[{wo_n, 5'b0} +: 32] : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_addr_q   <= '0;
      flush_pend_q <= 1'b0;
      cnt_q        <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        vptr_q[s]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      flush_pend_q <= flush_pend_d;
      cnt_q        <= cnt_d;
      if (flush_now) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (ram_we) begin
        valid_q[req_idx] <= set_valid | victim_oh;
        // pointer only advances when the set was full
        if (&set_valid && WAYS > 1) vptr_q[req_idx] <= vptr_q[req_idx] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat_we) rbuf_q[{cnt_q, 5'b0} +: 32] <= mem_rdata_i;
    for (int w = 0; w < WAYS; w++) begin
      if (ram_we && victim_oh[w]) begin
        data_ram[w][req_idx] <= rbuf_q;
        tag_ram[w][req_idx]  <= req_tag;
      end
      data_rd[w] <= data_ram[w][rd_idx];
      tag_rd[w]  <= tag_ram[w][rd_idx];
    end
  end
endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway (WAYS=2, SETS=128, LINE_WORDS=8): table of hit
// vectors plus hand-written miss, replacement, flush and reset sequences.
module tb_icache_nway;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        hit_o, inst_valid_o, inst2_valid_o, stall_o, mem_ren_o;
  logic [31:0] inst1_o, inst2_o, mem_araddr_o;
  logic        mem_arready_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int checks = 0;
  int failures = 0;

  icache_nway #(.WAYS(2), .SETS(128), .LINE_WORDS(8)) dut (
    .clk(clk), .rst(rst), .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i),
    .flush_i(flush_i), .hit_o(hit_o), .inst_valid_o(inst_valid_o), .inst1_o(inst1_o),
    .inst2_valid_o(inst2_valid_o), .inst2_o(inst2_o), .stall_o(stall_o),
    .mem_ren_o(mem_ren_o), .mem_araddr_o(mem_araddr_o), .mem_arready_i(mem_arready_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] e1;
    logic        e2v;
    logic [31:0] e2;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_out(input string name, input logic h, input logic v, input logic [31:0] e1,
                         input logic e2v, input logic [31:0] e2, input logic st);
    chk({name, ".hit"},   32'(hit_o), 32'(h));
    chk({name, ".valid"}, 32'(inst_valid_o), 32'(v));
    chk({name, ".inst1"}, inst1_o, e1);
    chk({name, ".v2"},    32'(inst2_valid_o), 32'(e2v));
    chk({name, ".inst2"}, inst2_o, e2);
    chk({name, ".stall"}, 32'(stall_o), 32'(st));
  endtask

  // Full miss service; expects the cache in IDLE. Line holds base+0 .. base+7.
  task automatic do_miss(input logic [31:0] addr, input logic [31:0] base, input int arwait,
                         input bit gap, input int flush_beat);
    logic [31:0] wo, e1, e2;
    logic        e2v;
    wo  = (addr >> 2) & 32'h7;
    e1  = base + wo;
    e2v = (wo < 7);
    e2  = e2v ? base + wo + 1 : 32'h0;
    cpu_req_i = 1'b1; cpu_addr_i = addr;
    #1 chk("miss.idle_stall", 32'(stall_o), 32'd1);
    step();
    cpu_req_i = 1'b0;
    #1 chk("miss.lookup_hit", 32'(hit_o), 32'd0);
    chk("miss.lookup_stall", 32'(stall_o), 32'd1);
    step();
    for (int i = 0; i < arwait; i++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
      #1 chk("miss.ren_wait", 32'(mem_ren_o), 32'd1);
      chk("miss.araddr_wait", mem_araddr_o, addr & ~32'h1F);
      step();
    end
    mem_rvalid_i = 1'b0; mem_arready_i = 1'b1;
    #1 chk("miss.ren", 32'(mem_ren_o), 32'd1);
    chk("miss.araddr", mem_araddr_o, addr & ~32'h1F);
    step();
    mem_arready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (gap && i == 4) begin
        mem_rvalid_i = 1'b0; flush_i = 1'b0;
        #1 chk("miss.gap_stall", 32'(stall_o), 32'd1);
        step();
      end
      mem_rvalid_i = 1'b1; mem_rdata_i = base + 32'(i);
      flush_i = (i == flush_beat);
      #1 chk("miss.refill_ren", 32'(mem_ren_o), 32'd0);
      step();
    end
    mem_rvalid_i = 1'b0; flush_i = 1'b0;
    #1 chk_out("miss.write", 1'b0, 1'b1, e1, e2v, e2, 1'b0);
    step();
  endtask

  task automatic do_hit(input string name, input logic [31:0] addr, input logic [31:0] e1,
                        input logic e2v, input logic [31:0] e2);
    cpu_req_i = 1'b1; cpu_addr_i = addr;
    step();
    cpu_req_i = 1'b0;
    #1 chk_out(name, 1'b1, 1'b1, e1, e2v, e2, 1'b0);
    step();
  endtask

  initial begin
    tbl[0] = '{32'h0000_1008, 32'hA2, 1'b1, 32'hA3};
    tbl[1] = '{32'h0000_101C, 32'hA7, 1'b0, 32'h0};
    tbl[2] = '{32'h0000_1000, 32'hA0, 1'b1, 32'hA1};
    tbl[3] = '{32'h0000_1018, 32'hA6, 1'b1, 32'hA7};
    tbl[4] = '{32'h0000_2040, 32'hB0, 1'b1, 32'hB1};
    tbl[5] = '{32'h0000_205C, 32'hB7, 1'b0, 32'h0};
    tbl[6] = '{32'h0000_2050, 32'hB4, 1'b1, 32'hB5};

    step(); step();
    #1 chk_out("reset", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("reset.ren", 32'(mem_ren_o), 32'd0);
    chk("reset.araddr", mem_araddr_o, 32'h0);
    step();
    rst = 1'b0;
    step();

    // cold miss with two wait states, then the same request hits
    do_miss(32'h0000_1008, 32'hA0, 2, 1'b0, -1);
    do_hit("cold_rehit", 32'h0000_1008, 32'hA2, 1'b1, 32'hA3);
    // second line, zero wait states and a gap between beats
    do_miss(32'h0000_2040, 32'hB0, 0, 1'b1, -1);

    for (int i = 0; i < 7; i++) begin
      cpu_req_i = 1'b1; cpu_addr_i = tbl[i].addr;
      step();
      cpu_req_i = 1'b0;
      #1 chk_out($sformatf("tbl%0d", i), 1'b1, 1'b1, tbl[i].e1, tbl[i].e2v, tbl[i].e2, 1'b0);
      step();
    end

    // back-to-back hits
    cpu_req_i = 1'b1; cpu_addr_i = 32'h0000_1000;
    step();
    cpu_addr_i = 32'h0000_1008;
    #1 chk_out("b2b0", 1'b1, 1'b1, 32'hA0, 1'b1, 32'hA1, 1'b0);
    step();
    cpu_addr_i = 32'h0000_1010;
    #1 chk_out("b2b1", 1'b1, 1'b1, 32'hA2, 1'b1, 32'hA3, 1'b0);
    step();
    cpu_req_i = 1'b0;
    #1 chk_out("b2b2", 1'b1, 1'b1, 32'hA4, 1'b1, 32'hA5, 1'b0);
    step();
    #1 chk("b2b.idle_stall", 32'(stall_o), 32'd0);

    // replacement in index 0: way0=0x1000, way1=0x2000, then round-robin
    do_miss(32'h0000_2000, 32'hC0, 1, 1'b0, -1);
    do_miss(32'h0000_3000, 32'hD0, 0, 1'b0, -1);
    do_hit("repl_2000", 32'h0000_2000, 32'hC0, 1'b1, 32'hC1);
    do_miss(32'h0000_1000, 32'hA0, 0, 1'b0, -1);
    do_hit("repl_3004", 32'h0000_3004, 32'hD1, 1'b1, 32'hD2);
    do_miss(32'h0000_2000, 32'hC0, 0, 1'b0, -1);
    do_hit("repl_1000", 32'h0000_1000, 32'hA0, 1'b1, 32'hA1);

    // flush during refill: write still returns data, pending flush runs in IDLE
    do_miss(32'h0000_4000, 32'hE0, 0, 1'b0, 3);
    #1 chk("flush.pend_stall", 32'(stall_o), 32'd1);
    step();
    #1 chk("flush.after_stall", 32'(stall_o), 32'd0);
    do_miss(32'h0000_4000, 32'hE0, 0, 1'b0, -1);
    do_miss(32'h0000_2040, 32'hB0, 0, 1'b0, -1);

    // flush in IDLE wins over a simultaneous request, which stays pending
    cpu_req_i = 1'b1; cpu_addr_i = 32'h0000_4000; flush_i = 1'b1;
    #1 chk("idle_flush.stall", 32'(stall_o), 32'd1);
    step();
    flush_i = 1'b0;
    do_miss(32'h0000_4000, 32'hE0, 1, 1'b0, -1);

    // reset while MISS holds the read request: mem_ren_o drops at once
    cpu_req_i = 1'b1; cpu_addr_i = 32'h0000_6000;
    step();
    cpu_req_i = 1'b0;
    step();
    #1 chk("rst_miss.ren_before", 32'(mem_ren_o), 32'd1);
    rst = 1'b1;
    #1 chk("rst_miss.ren_after", 32'(mem_ren_o), 32'd0);
    chk("rst_miss.araddr", mem_araddr_o, 32'h0);
    step();
    rst = 1'b0;
    step();

    // reset after three refill beats abandons the line
    cpu_req_i = 1'b1; cpu_addr_i = 32'h0000_5040;
    step();
    cpu_req_i = 1'b0;
    step();
    mem_arready_i = 1'b1;
    step();
    mem_arready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hF0 + 32'(i);
      step();
    end
    mem_rvalid_i = 1'b0;
    #1 chk("rst_refill.stall_before", 32'(stall_o), 32'd1);
    rst = 1'b1;
    #1 chk_out("rst_refill", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("rst_refill.ren", 32'(mem_ren_o), 32'd0);
    step();
    rst = 1'b0;
    step();
    do_miss(32'h0000_5040, 32'hF0, 0, 1'b0, -1);
    do_miss(32'h0000_1000, 32'hA0, 0, 1'b0, -1);
    do_hit("post_rst_5044", 32'h0000_5044, 32'hF1, 1'b1, 32'hF2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
